// File: rtl/axil_bus_master_pkg.sv
// rtl/axil_bus_master_pkg.sv - state encoding and AXI constants for axil_bus_master
package axil_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DRAIN   = 3'd5
  } axil_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [7:0] TIMEOUT_RDATA   = 8'hFF;

endpackage

// File: rtl/axil_byte_lane.sv
// rtl/axil_byte_lane.sv - byte-lane alignment of write data/strobes and read byte extraction
module axil_byte_lane (
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [7:0]  o_rbyte
);

  logic [4:0] w_shift;

  assign w_shift = {i_lane, 3'b000};
  // Strobes shifted past lane 3 fall off the top of the 4-bit bus.
  assign o_wdata = i_wdata << w_shift;
  assign o_wstrb = i_wstrb << i_lane;
  assign o_rbyte = i_rdata[w_shift +: 8];

endmodule

// File: rtl/axil_bus_master.sv
// rtl/axil_bus_master.sv - single-outstanding AXI4-Lite master for byte-wide CPU requests
// Optional watchdog with DRAIN recovery enabled by AXIL_BUS_MASTER_TIMEOUT_EN.
module axil_bus_master
  import axil_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_read,
  input  logic [31:0] req_A32,
  input  logic [31:0] req_D32,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  axil_state_t r_state;
  logic        r_is_read;
  logic        r_ar_done;
  logic        r_aw_done;
  logic        r_w_done;
  logic [1:0]  r_lane;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [7:0]  r_rsp_rdata;

  logic [1:0]  w_lane;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_rbyte;
  logic        w_ar_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_r_hs;
  logic        w_b_hs;
  logic        w_drain_rd;
  logic        w_drain_wr;
  logic        w_timeout;

  assign req_ready = (r_state == ST_IDLE);

  // Lane comes from the live request while idle, from the latched address otherwise.
  assign w_lane = req_ready ? req_A32[1:0] : r_lane;

  axil_byte_lane u_byte_lane (
    .i_lane  (w_lane),
    .i_wdata (req_D32),
    .i_wstrb (req_wstrb),
    .i_rdata (m_rdata),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb),
    .o_rbyte (w_rbyte)
  );

`ifdef AXIL_BUS_MASTER_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (req_ready) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_timeout  = (r_cnt == 16'(TIMEOUT_CYCLES - 1)) && !req_ready && (r_state != ST_DRAIN);
  assign w_drain_rd = (r_state == ST_DRAIN) && r_is_read;
  assign w_drain_wr = (r_state == ST_DRAIN) && !r_is_read;
`else
  assign w_timeout  = 1'b0;
  assign w_drain_rd = 1'b0;
  assign w_drain_wr = 1'b0;
`endif

  // DRAIN finishes whatever handshakes the abandoned transaction still owes.
  assign m_arvalid = (r_state == ST_RD_ADDR) || (w_drain_rd && !r_ar_done);
  assign m_rready  = (r_state == ST_RD_DATA) || (w_drain_rd && r_ar_done);
  assign m_awvalid = ((r_state == ST_WR_ADDR) || w_drain_wr) && !r_aw_done;
  assign m_wvalid  = ((r_state == ST_WR_ADDR) || w_drain_wr) && !r_w_done;
  assign m_bready  = (r_state == ST_WR_RESP) || (w_drain_wr && r_aw_done && r_w_done);

  assign m_araddr = r_addr;
  assign m_awaddr = r_addr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;

  assign w_ar_hs = m_arvalid && m_arready;
  assign w_aw_hs = m_awvalid && m_awready;
  assign w_w_hs  = m_wvalid && m_wready;
  assign w_r_hs  = m_rvalid && m_rready;
  assign w_b_hs  = m_bvalid && m_bready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_read   <= 1'b0;
      r_ar_done   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_lane      <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_ar_hs) r_ar_done <= 1'b1;
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;

      // A response arriving on the watchdog cycle still wins over the timeout.
      if (w_timeout && !w_r_hs && !w_b_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= TIMEOUT_RDATA;
        r_state     <= ST_DRAIN;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (req_valid) begin
              r_is_read <= req_is_read;
              r_lane    <= req_A32[1:0];
              r_addr    <= {req_A32[31:2], 2'b00};
              r_wdata   <= w_wdata;
              r_wstrb   <= w_wstrb;
              r_ar_done <= 1'b0;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= req_is_read ? ST_RD_ADDR : ST_WR_ADDR;
            end
          end
          ST_RD_ADDR: begin
            if (w_ar_hs) r_state <= ST_RD_DATA;
          end
          ST_RD_DATA: begin
            if (w_r_hs) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rbyte;
              r_rsp_err   <= (m_rresp & AXI_RESP_SLVERR) != AXI_RESP_OKAY;
              r_state     <= ST_IDLE;
            end
          end
          ST_WR_ADDR: begin
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= ST_WR_RESP;
          end
          ST_WR_RESP: begin
            if (w_b_hs) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 8'h00;
              r_rsp_err   <= (m_bresp & AXI_RESP_SLVERR) != AXI_RESP_OKAY;
              r_state     <= ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (w_r_hs || w_b_hs) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_bus_master.sv
// tb/tb_axil_bus_master.sv - scoreboard bench for axil_bus_master with a delay-programmable AXI-Lite slave
`timescale 1ns/1ps
module tb_axil_bus_master;
  import axil_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_is_read;
  logic [31:0] req_A32, req_D32;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  axil_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_read(req_is_read),
    .req_A32(req_A32), .req_D32(req_D32), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct { logic [7:0] rdata; logic err; int lat; int acc; } rsp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  rsp_t        q_rsp[$];
  logic [31:0] q_ar[$];
  logic [31:0] q_aw[$];
  w_t          q_w[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int aw_hi = 0;
  int w_hi = 0;
  int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic [31:0] s_rdata = 32'd0;
  logic [1:0]  s_rresp = 2'b00;
  logic [1:0]  s_bresp = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no matching event, expected one", name);
  endtask

  // Slave: each channel answers after its programmed number of wait cycles.
  always @(negedge clk) begin
    if (m_arvalid && ar_cnt >= ar_delay) begin m_arready = 1'b1; ar_cnt = 0; end
    else begin m_arready = 1'b0; ar_cnt = m_arvalid ? ar_cnt + 1 : 0; end
    if (m_awvalid && aw_cnt >= aw_delay) begin m_awready = 1'b1; aw_cnt = 0; end
    else begin m_awready = 1'b0; aw_cnt = m_awvalid ? aw_cnt + 1 : 0; end
    if (m_wvalid && w_cnt >= w_delay) begin m_wready = 1'b1; w_cnt = 0; end
    else begin m_wready = 1'b0; w_cnt = m_wvalid ? w_cnt + 1 : 0; end
    if (m_rready && r_cnt >= r_delay) begin
      m_rvalid = 1'b1; m_rdata = s_rdata; m_rresp = s_rresp; r_cnt = 0;
    end else begin
      m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'b00; r_cnt = m_rready ? r_cnt + 1 : 0;
    end
    if (m_bready && b_cnt >= b_delay) begin m_bvalid = 1'b1; m_bresp = s_bresp; b_cnt = 0; end
    else begin m_bvalid = 1'b0; m_bresp = 2'b00; b_cnt = m_bready ? b_cnt + 1 : 0; end
  end

  // Monitor: compares every handshake and response against the queues.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (m_awvalid) aw_hi++;
      if (m_wvalid) w_hi++;
      if (m_arvalid && m_arready) begin
        if (q_ar.size() == 0) fail("unexpected_ar");
        else check("araddr", m_araddr, q_ar.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (q_aw.size() == 0) fail("unexpected_aw");
        else check("awaddr", m_awaddr, q_aw.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (q_w.size() == 0) fail("unexpected_w");
        else begin
          w_t ew;
          ew = q_w.pop_front();
          check("wdata", m_wdata, ew.data);
          check("wstrb", {28'd0, m_wstrb}, {28'd0, ew.strb});
        end
      end
      if (m_bready) check("bready_before_aw_w_done", {30'd0, m_awvalid, m_wvalid}, 32'd0);
      if (rsp_valid) begin
        if (q_rsp.size() == 0) fail("unexpected_rsp");
        else begin
          rsp_t e;
          e = q_rsp.pop_front();
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) fail("req_ready_wait");
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (!rsp_valid) fail("rsp_wait");
  endtask

  // Called at a negedge with req_ready high; the request is accepted at the next posedge.
  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic push, input logic [7:0] erd, input logic eerr, input int elat);
    rsp_t e;
    req_valid = 1'b1; req_is_read = rd; req_A32 = a; req_D32 = d; req_wstrb = s;
    aw_hi = 0; w_hi = 0;
    e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = cyc;
    if (push) q_rsp.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    w_t w;
    req_valid = 1'b0; req_is_read = 1'b0; req_A32 = 32'd0; req_D32 = 32'd0; req_wstrb = 4'd0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    m_rdata = 32'd0; m_rresp = 2'b00; m_bresp = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_valids", {26'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, rsp_valid}, 32'd0);
    check("reset_rsp", {23'd0, rsp_err, rsp_rdata}, 32'd0);
    check("reset_addr", m_araddr | m_awaddr | m_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait read of lane 2
    q_ar.push_back(32'h4060_0000); s_rdata = 32'hA1B2_C3D4; s_rresp = AXI_RESP_OKAY;
    wait_ready(); send(1'b1, 32'h4060_0002, 32'd0, 4'd0, 1'b1, 8'hB2, 1'b0, 3); wait_rsp();

    // Zero-wait write to lane 3
    q_aw.push_back(32'h1000_0000); w.data = 32'h5A00_0000; w.strb = 4'b1000; q_w.push_back(w);
    s_bresp = AXI_RESP_OKAY;
    wait_ready(); send(1'b0, 32'h1000_0003, 32'h0000_005A, 4'b0001, 1'b1, 8'h00, 1'b0, 3); wait_rsp();

    // Late AWREADY, immediate WREADY
    aw_delay = 2;
    q_aw.push_back(32'h2000_0000); w.data = 32'h0000_C300; w.strb = 4'b0110; q_w.push_back(w);
    wait_ready(); send(1'b0, 32'h2000_0001, 32'h0000_00C3, 4'b0011, 1'b1, 8'h00, 1'b0, 5); wait_rsp();
    check("awvalid_cycles_late_aw", aw_hi, 3);
    check("wvalid_cycles_late_aw", w_hi, 1);

    // Late WREADY, strobes truncated at lane 2, SLVERR write response
    aw_delay = 0; w_delay = 2; s_bresp = AXI_RESP_SLVERR;
    q_aw.push_back(32'h3000_0004); w.data = 32'h5678_0000; w.strb = 4'b1100; q_w.push_back(w);
    wait_ready(); send(1'b0, 32'h3000_0006, 32'h1234_5678, 4'b1111, 1'b1, 8'h00, 1'b1, 5); wait_rsp();
    check("awvalid_cycles_late_w", aw_hi, 1);
    check("wvalid_cycles_late_w", w_hi, 3);

    // SLVERR read then a request accepted in the rsp_valid cycle
    w_delay = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = AXI_RESP_SLVERR;
    q_ar.push_back(32'h0000_0010);
    wait_ready(); send(1'b1, 32'h0000_0013, 32'd0, 4'd0, 1'b1, 8'hDE, 1'b1, 3); wait_rsp();
    check("req_ready_in_rsp_cycle", {31'd0, req_ready}, 32'd1);
    s_rdata = 32'h1122_3344; s_rresp = 2'b01; r_delay = 2;
    q_ar.push_back(32'h0000_0020);
    send(1'b1, 32'h0000_0021, 32'd0, 4'd0, 1'b1, 8'h33, 1'b0, 5); wait_rsp();

    // R withheld until 40 cycles after accept
    r_delay = 38; s_rdata = 32'hCAFE_F00D; s_rresp = AXI_RESP_OKAY;
    q_ar.push_back(32'h5000_0000);
    wait_ready();
    acc = cyc;
`ifdef AXIL_BUS_MASTER_TIMEOUT_EN
    send(1'b1, 32'h5000_0001, 32'd0, 4'd0, 1'b1, TIMEOUT_RDATA, 1'b1, 17);
`else
    send(1'b1, 32'h5000_0001, 32'd0, 4'd0, 1'b1, 8'hF0, 1'b0, 41);
`endif
    n = 0;
    @(negedge clk); #1;
    while (!(m_rvalid && m_rready) && n < 100) begin
      if (req_ready) begin fail("req_ready_low_until_r"); n = 100; end
      @(negedge clk); #1;
      n++;
    end
    if (!(m_rvalid && m_rready)) fail("r_handshake_wait");
    check("r_handshake_cycle", cyc - acc, 40);
    check("req_ready_at_r_handshake", {31'd0, req_ready}, 32'd0);
    @(negedge clk); #1;
    check("req_ready_after_r", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset while in RD_DATA
    r_delay = 50;
    q_ar.push_back(32'h6000_0000);
    wait_ready(); send(1'b1, 32'h6000_0000, 32'd0, 4'd0, 1'b0, 8'h00, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("rready_before_reset", {31'd0, m_rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valids", {26'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Recovery read after reset
    r_delay = 0; s_rdata = 32'h0000_AB00; s_rresp = AXI_RESP_OKAY;
    q_ar.push_back(32'h7000_0000);
    wait_ready(); send(1'b1, 32'h7000_0001, 32'd0, 4'd0, 1'b1, 8'hAB, 1'b0, 3); wait_rsp();

    repeat (5) @(negedge clk);
    check("rsp_queue_empty", q_rsp.size(), 0);
    check("ar_queue_empty", q_ar.size(), 0);
    check("aw_queue_empty", q_aw.size(), 0);
    check("w_queue_empty", q_w.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
